regfile_banked: RTL
===================

# regfile_banked

Parametrised successor to the pipeline register file: configurable data width and register count, two combinational read ports plus a dedicated auxiliary-register read, a primary write port and an auxiliary write port, optional write-to-read bypass, and a shadow bank with a save/restore state machine for interrupt context switching. It sits in the decode stage; writeback drives the write ports, and the interrupt controller drives save/restore.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers
- AUX_REG, 15, index written by the auxiliary port and read on rd_data_aux
- BYPASS, 1, 1 = reads return same-cycle write data
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses
- rd_data_a, rd_data_b  out  DATA_W  read data
- rd_data_aux  out  DATA_W  contents of AUX_REG
- wr_en  in  1  primary write enable
- wr_addr  in  ADDR_W  primary write address
- wr_data  in  DATA_W  primary write data
- aux_wr_en  in  1  auxiliary write enable (target AUX_REG)
- aux_wr_data  in  DATA_W  auxiliary write data
- save_req, restore_req  in  1  context save/restore request, sampled in IDLE
- busy  out  1  save/restore in progress
- done  out  1  one-cycle completion pulse

## Operation
- Reset values, 16-bit view, zero-extended or truncated to DATA_W: R1 FFFF, R2 0050, R3 F033, R4 F0FF, R5 0040, R6 6666, R7 00FF, R8 8888, R12 CCCC, R13 0002, all others 0. Shadow bank is all 0. FSM is IDLE; busy=0 and done=0.
- Reads are combinational from the array.
- BYPASS=1: if a read address matches an enabled write this cycle, return that write data. If both ports target the same address, the primary write data wins.
- BYPASS=0: reads return pre-edge contents.
- Writes commit on the rising edge.
- Primary and auxiliary writes to different addresses both commit.
- If wr_addr==AUX_REG with both enables high, only the primary write commits.
- No hardwired-zero register; R0 is writable.
- FSM states are IDLE, SAVE and RESTORE, with a copy index idx (ADDR_W bits).
- IDLE:
  - save_req moves to SAVE with idx=0.
  - Otherwise, restore_req moves to RESTORE with idx=0.
  - Save wins if both are high.
- SAVE: each edge copies array[idx] into shadow[idx] and increments idx.
  - Architectural writes still commit.
  - A same-edge write to register idx stores the old value in shadow and the new value in the array.
- RESTORE: each edge copies shadow[idx] into array[idx] and increments idx.
  - wr_en and aux_wr_en are ignored; the pipeline stalls on busy.
  - Bypass is disabled.
- After copying idx=NREGS-1, return to IDLE and assert done.
- Requests while busy are ignored and not queued.
- idx wraps naturally and never exceeds NREGS-1.

## Timing
- Read latency is 0 cycles; write-to-read latency is 1 edge, or 0 with BYPASS.
- Request accepted at edge T:
  - busy=1 from T through T+NREGS.
  - Copies occur at edges T+1..T+NREGS.
  - busy=0 and done=1 during the cycle after T+NREGS, for one cycle only.
- A new request can be accepted in the cycle where done=1.
- rst asserted mid-operation immediately:
  - reloads the reset values,
  - clears the shadow bank,
  - forces IDLE with busy=0 and done=0.
  - A partial copy is discarded.
- rd_data_aux always equals the read of AUX_REG, including bypass.

## Structure
- Package regfile_pkg holds:
  - the FSM state enum (IDLE/SAVE/RESTORE),
  - the AUX_REG default constant,
  - a function reset_value(index, DATA_W) returning the reset table.
- One sub-module, regfile_ctx_fsm, owns the state, idx, busy and done, and emits copy_save/copy_restore strobes plus idx.
- The top-level regfile_banked owns both arrays, the write muxing and the bypass.

## Test plan
- Reset: assert rst, read all 16 registers -> R2=0050, R12=CCCC, R9=0000, busy=0, done=0.
- Dual write: wr R3←1234 and aux←ABCD same edge -> R3=1234, rd_data_aux=ABCD. Then wr R15←5555 with aux←AAAA -> R15=5555.
- Bypass: BYPASS=1, wr R6←0F0F with rd_addr_a=6 the same cycle -> rd_data_a=0F0F before the edge. BYPASS=0 -> 6666.
- Save/restore:
  - save_req, then check busy high for 16 cycles and done after.
  - Overwrite R1←0000, then restore_req.
  - After done, R1=FFFF; wr_en during RESTORE has no effect.
- Save with collision: write R5←7777 on the edge copying idx=5, restore -> R5=0040.
- Reset mid-save at idx=8 -> busy=0 immediately, shadow=0, and a following restore leaves all registers 0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types, constants and reset table for the banked register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } ctx_state_t;

    localparam int C_AUX_REG_DEFAULT = 15;

    // 16-bit reset image, zero-extended or truncated to data_w.
    function automatic logic [63:0] reset_value(input int unsigned index, input int unsigned data_w);
        logic [15:0] v;
        logic [63:0] mask;
        case (index)
            1:       v = 16'hFFFF;
            2:       v = 16'h0050;
            3:       v = 16'hF033;
            4:       v = 16'hF0FF;
            5:       v = 16'h0040;
            6:       v = 16'h6666;
            7:       v = 16'h00FF;
            8:       v = 16'h8888;
            12:      v = 16'hCCCC;
            13:      v = 16'h0002;
            default: v = 16'h0000;
        endcase
        mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
        return {48'd0, v} & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_banked_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_banked_if
// Brief    : Read/write/context-switch bus of the banked register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_banked_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] rd_data_aux;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              aux_wr_en;
    logic [DATA_W-1:0] aux_wr_data;
    logic              save_req;
    logic              restore_req;
    logic              busy;
    logic              done;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               aux_wr_en, aux_wr_data, save_req, restore_req,
        input  rd_data_a, rd_data_b, rd_data_aux, busy, done
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               aux_wr_en, aux_wr_data, save_req, restore_req,
        output rd_data_a, rd_data_b, rd_data_aux, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_ctx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctx_fsm
// Brief    : Save/restore sequencer walking idx over every register once.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_ctx_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_save_req,
    input  wire logic              i_restore_req,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_copy_save,
    output logic                   o_copy_restore,
    output logic [ADDR_W-1:0]      o_idx
);

    ctx_state_t        r_state;
    ctx_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_done;
    logic              w_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Save has priority when both requests arrive together.
                if (i_save_req) begin
                    w_state_nxt = ST_SAVE;
                    w_idx_nxt   = '0;
                end else if (i_restore_req) begin
                    w_state_nxt = ST_RESTORE;
                    w_idx_nxt   = '0;
                end
            end
            ST_SAVE, ST_RESTORE: begin
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == '1) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = r_done;
    assign o_copy_save    = (r_state == ST_SAVE);
    assign o_copy_restore = (r_state == ST_RESTORE);
    assign o_idx          = r_idx;

endmodule
`default_nettype wire

// File: rtl/regfile_banked.sv
`default_nettype none
// ============================================================================
// Module   : regfile_banked
// Brief    : Parametrised register file with aux port, bypass and shadow bank.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_banked
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int AUX_REG = C_AUX_REG_DEFAULT,
    parameter int BYPASS  = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    regfile_banked_if.slave bus
);

    localparam int                NREGS      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_AUX_ADDR = ADDR_W'(AUX_REG);

    logic [DATA_W-1:0] r_regs   [NREGS];
    logic [DATA_W-1:0] r_shadow [NREGS];

    logic              w_busy;
    logic              w_done;
    logic              w_copy_save;
    logic              w_copy_restore;
    logic [ADDR_W-1:0] w_idx;
    logic              w_wr_pri;
    logic              w_wr_aux;
    logic [ADDR_W-1:0] w_rd_addr [3];
    logic [DATA_W-1:0] w_rd_data [3];

    regfile_ctx_fsm #(
        .ADDR_W (ADDR_W)
    ) u_ctx_fsm (
        .clk            (clk),
        .rst            (rst),
        .i_save_req     (bus.save_req),
        .i_restore_req  (bus.restore_req),
        .o_busy         (w_busy),
        .o_done         (w_done),
        .o_copy_save    (w_copy_save),
        .o_copy_restore (w_copy_restore),
        .o_idx          (w_idx)
    );

    // Restore owns the array, so architectural writes are dropped while it runs.
    assign w_wr_pri = bus.wr_en & ~w_copy_restore;
    assign w_wr_aux = bus.aux_wr_en & ~w_copy_restore & ~(w_wr_pri && (bus.wr_addr == C_AUX_ADDR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i[ADDR_W-1:0]] <= DATA_W'(reset_value(i, DATA_W));
            end
        end else if (w_copy_restore) begin
            r_regs[w_idx] <= r_shadow[w_idx];
        end else begin
            if (w_wr_aux) begin
                r_regs[C_AUX_ADDR] <= bus.aux_wr_data;
            end
            if (w_wr_pri) begin
                r_regs[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Shadow captures the pre-edge array value even if the same register is written now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_shadow[i[ADDR_W-1:0]] <= '0;
            end
        end else if (w_copy_save) begin
            r_shadow[w_idx] <= r_regs[w_idx];
        end
    end

    assign w_rd_addr[0] = bus.rd_addr_a;
    assign w_rd_addr[1] = bus.rd_addr_b;
    assign w_rd_addr[2] = C_AUX_ADDR;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rd_data[p] = r_regs[w_rd_addr[p]];
            if ((BYPASS != 0) && !w_copy_restore) begin
                if (w_wr_pri && (bus.wr_addr == w_rd_addr[p])) begin
                    w_rd_data[p] = bus.wr_data;
                end else if (w_wr_aux && (C_AUX_ADDR == w_rd_addr[p])) begin
                    w_rd_data[p] = bus.aux_wr_data;
                end
            end
        end
    end

    assign bus.rd_data_a   = w_rd_data[0];
    assign bus.rd_data_b   = w_rd_data[1];
    assign bus.rd_data_aux = w_rd_data[2];
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;

endmodule
`default_nettype wire
